// File: rtl/cdb_issue_queue_pkg.sv
// cdb_issue_queue_pkg: shared defaults for the CDB-snooping issue queue.
package cdb_issue_queue_pkg;
  localparam int CDB_CH_DEFAULT       = 1;
  localparam int IQ_DEPTH_DEFAULT     = 4;
  localparam int IQ_TAG_W_DEFAULT     = 6;
  localparam int IQ_DATA_W_DEFAULT    = 32;
  localparam int IQ_PAYLOAD_W_DEFAULT = 17;
endpackage

// File: rtl/cdb_issue_queue_oldest_ready_sel.sv
// iq_oldest_ready_sel: lowest-index (oldest) ready entry as one-hot and binary index.
module iq_oldest_ready_sel
  import cdb_issue_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH_DEFAULT
) (
  input  logic [DEPTH-1:0]         i_ready,
  output logic                     o_valid,
  output logic [DEPTH-1:0]         o_onehot,
  output logic [$clog2(DEPTH)-1:0] o_idx
);
  localparam int IW = $clog2(DEPTH);
  assign o_valid  = |i_ready;
  assign o_onehot = i_ready & (~i_ready + DEPTH'(1));
  always_comb begin
    o_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (i_ready[i]) o_idx = IW'(i);
  end
endmodule

// File: rtl/cdb_issue_queue.sv
// cdb_issue_queue: age-ordered compacting issue queue with CDB wakeup; CDB_DISPATCH_BYPASS_EN wakes operands at dispatch.
module cdb_issue_queue
  import cdb_issue_queue_pkg::*;
#(
  parameter int DEPTH     = IQ_DEPTH_DEFAULT,
  parameter int TAG_W     = IQ_TAG_W_DEFAULT,
  parameter int DATA_W    = IQ_DATA_W_DEFAULT,
  parameter int PAYLOAD_W = IQ_PAYLOAD_W_DEFAULT,
  parameter int N_CDB     = CDB_CH_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_flush,
  input  logic                         i_dispatch_en,
  input  logic [DATA_W-1:0]            i_dispatch_rs1_data,
  input  logic [DATA_W-1:0]            i_dispatch_rs2_data,
  input  logic                         i_dispatch_rs1_valid,
  input  logic                         i_dispatch_rs2_valid,
  input  logic [TAG_W-1:0]             i_dispatch_rs1_tag,
  input  logic [TAG_W-1:0]             i_dispatch_rs2_tag,
  input  logic [TAG_W-1:0]             i_dispatch_rd_tag,
  input  logic [PAYLOAD_W-1:0]         i_dispatch_payload,
  output logic                         o_queue_full,
  output logic                         o_queue_empty,
  input  logic [N_CDB-1:0]             i_cdb_valid,
  input  logic [N_CDB*TAG_W-1:0]       i_cdb_tag,
  input  logic [N_CDB*DATA_W-1:0]      i_cdb_result,
  output logic                         o_issue_valid,
  input  logic                         i_issue_ack,
  output logic [DATA_W-1:0]            o_issue_rs1_data,
  output logic [DATA_W-1:0]            o_issue_rs2_data,
  output logic [TAG_W-1:0]             o_issue_rd_tag,
  output logic [PAYLOAD_W-1:0]         o_issue_payload,
  output logic [$clog2(DEPTH+1)-1:0]   o_occupancy
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef struct packed {
    logic                 valid;
    logic                 rs1_valid;
    logic [TAG_W-1:0]     rs1_tag;
    logic [DATA_W-1:0]    rs1_data;
    logic                 rs2_valid;
    logic [TAG_W-1:0]     rs2_tag;
    logic [DATA_W-1:0]    rs2_data;
    logic [TAG_W-1:0]     rd_tag;
    logic [PAYLOAD_W-1:0] payload;
  } iq_entry_t;
  iq_entry_t        r_q [DEPTH];
  logic [CW-1:0]    r_count;
  iq_entry_t        w_wk [DEPTH];
  iq_entry_t        w_sh [DEPTH];
  iq_entry_t        w_nq [DEPTH];
  iq_entry_t        w_raw;
  iq_entry_t        w_din;
  logic [DEPTH-1:0] w_ready;
  logic [DEPTH-1:0] w_onehot;
  logic [IW-1:0]    w_idx;
  logic             w_iss;
  logic             w_disp;
  logic             w_dup;
  logic [CW-1:0]    w_wr;
  function automatic iq_entry_t f_wake(input iq_entry_t e);
    iq_entry_t r;
    r = e;
    for (int c = 0; c < N_CDB; c++)
      if (i_cdb_valid[c]) begin
        if (!e.rs1_valid && e.rs1_tag == i_cdb_tag[c*TAG_W +: TAG_W]) begin
          r.rs1_valid = 1'b1;
          r.rs1_data  = i_cdb_result[c*DATA_W +: DATA_W];
        end
        if (!e.rs2_valid && e.rs2_tag == i_cdb_tag[c*TAG_W +: TAG_W]) begin
          r.rs2_valid = 1'b1;
          r.rs2_data  = i_cdb_result[c*DATA_W +: DATA_W];
        end
      end
    return r;
  endfunction
  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      w_ready[i] = r_q[i].valid & r_q[i].rs1_valid & r_q[i].rs2_valid;
  end
  iq_oldest_ready_sel #(.DEPTH(DEPTH)) u_sel (
    .i_ready  (w_ready),
    .o_valid  (o_issue_valid),
    .o_onehot (w_onehot),
    .o_idx    (w_idx)
  );
  assign w_iss  = o_issue_valid & i_issue_ack;
  assign w_disp = i_dispatch_en & ~o_queue_full;
  assign w_wr   = r_count - CW'(w_iss);
  assign w_raw  = '{valid: 1'b1,
                    rs1_valid: i_dispatch_rs1_valid, rs1_tag: i_dispatch_rs1_tag, rs1_data: i_dispatch_rs1_data,
                    rs2_valid: i_dispatch_rs2_valid, rs2_tag: i_dispatch_rs2_tag, rs2_data: i_dispatch_rs2_data,
                    rd_tag: i_dispatch_rd_tag, payload: i_dispatch_payload};
`ifdef CDB_DISPATCH_BYPASS_EN
  assign w_din = f_wake(w_raw);
`else
  assign w_din = w_raw;
`endif
  always_comb begin
    for (int i = 0; i < DEPTH; i++) w_wk[i] = f_wake(r_q[i]);
  end
  always_comb begin
    for (int i = 0; i < DEPTH; i++) w_sh[i] = '0;
    for (int i = 0; i < DEPTH - 1; i++) w_sh[i] = w_wk[i+1];
  end
  // Issued slot closes the gap; the new entry lands just past the surviving tail.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_nq[i] = (w_iss && IW'(i) >= w_idx) ? w_sh[i] : w_wk[i];
      if (w_disp && CW'(i) == w_wr) w_nq[i] = w_din;
    end
  end
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
    end else begin
      r_count <= r_count + CW'(w_disp) - CW'(w_iss);
      r_q     <= w_nq;
    end
  end
  always_comb begin
    o_issue_rs1_data = '0;
    o_issue_rs2_data = '0;
    o_issue_rd_tag   = '0;
    o_issue_payload  = '0;
    for (int i = 0; i < DEPTH; i++)
      if (w_onehot[i]) begin
        o_issue_rs1_data = o_issue_rs1_data | r_q[i].rs1_data;
        o_issue_rs2_data = o_issue_rs2_data | r_q[i].rs2_data;
        o_issue_rd_tag   = o_issue_rd_tag | r_q[i].rd_tag;
        o_issue_payload  = o_issue_payload | r_q[i].payload;
      end
  end
  assign o_occupancy   = r_count;
  assign o_queue_full  = r_count == CW'(DEPTH);
  assign o_queue_empty = r_count == '0;
  always_comb begin
    w_dup = 1'b0;
    for (int a = 0; a < N_CDB; a++)
      for (int b = a + 1; b < N_CDB; b++)
        if (i_cdb_valid[a] && i_cdb_valid[b] && i_cdb_tag[a*TAG_W +: TAG_W] == i_cdb_tag[b*TAG_W +: TAG_W])
          w_dup = 1'b1;
  end
  a_unique_broadcast: assert property (@(posedge clk) disable iff (rst) !w_dup);
endmodule

// File: tb/tb_cdb_issue_queue.sv
// tb_cdb_issue_queue: directed vector table, corner sequences and a random run against a queue model.
module tb_cdb_issue_queue;
  localparam int DEPTH = 4;
  localparam int TW = 6;
  localparam int DW = 32;
  localparam int PW = 17;
  localparam int NC = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush, den, d_r1v, d_r2v, ack, full, empty, iv;
  logic [DW-1:0] d_r1d, d_r2d, o_r1, o_r2;
  logic [TW-1:0] d_r1t, d_r2t, d_rd, o_rd;
  logic [PW-1:0] d_pl, o_pl;
  logic [NC-1:0] cv;
  logic [NC*TW-1:0] ct;
  logic [NC*DW-1:0] cr;
  logic [2:0] occ;
  int n_pass = 0;
  int n_tot = 0;

  cdb_issue_queue #(.DEPTH(DEPTH), .TAG_W(TW), .DATA_W(DW), .PAYLOAD_W(PW), .N_CDB(NC)) dut (
    .clk(clk), .rst(rst), .i_flush(flush), .i_dispatch_en(den),
    .i_dispatch_rs1_data(d_r1d), .i_dispatch_rs2_data(d_r2d),
    .i_dispatch_rs1_valid(d_r1v), .i_dispatch_rs2_valid(d_r2v),
    .i_dispatch_rs1_tag(d_r1t), .i_dispatch_rs2_tag(d_r2t),
    .i_dispatch_rd_tag(d_rd), .i_dispatch_payload(d_pl),
    .o_queue_full(full), .o_queue_empty(empty),
    .i_cdb_valid(cv), .i_cdb_tag(ct), .i_cdb_result(cr),
    .o_issue_valid(iv), .i_issue_ack(ack),
    .o_issue_rs1_data(o_r1), .o_issue_rs2_data(o_r2),
    .o_issue_rd_tag(o_rd), .o_issue_payload(o_pl), .o_occupancy(occ)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic flush, den;
    logic [TW-1:0] rd;
    logic ack, e_full, e_empty, e_iv;
    logic [TW-1:0] e_rd;
    logic [2:0] e_occ;
  } vec_t;

  typedef struct {
    logic a_v;
    logic [TW-1:0] a_t;
    logic [DW-1:0] a_d;
    logic b_v;
    logic [TW-1:0] b_t;
    logic [DW-1:0] b_d;
    logic [TW-1:0] rd;
    logic [PW-1:0] pl;
  } ment_t;

  vec_t tbl[$];
  ment_t mq[$];

  function automatic vec_t mkv(int fl, int dn, int rd, int ak, int f, int e, int v, int erd, int o);
    vec_t r;
    r.flush = fl[0]; r.den = dn[0]; r.rd = rd[TW-1:0]; r.ack = ak[0];
    r.e_full = f[0]; r.e_empty = e[0]; r.e_iv = v[0]; r.e_rd = erd[TW-1:0]; r.e_occ = o[2:0];
    return r;
  endfunction

  function automatic logic [127:0] expv(input logic f, input logic e, input logic v, input logic [TW-1:0] rd,
                                       input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [PW-1:0] p,
                                       input logic [2:0] o);
    return 128'({f, e, v, rd, a, b, p, o});
  endfunction

  function automatic logic [127:0] obs();
    return 128'({full, empty, iv, o_rd, o_r1, o_r2, o_pl, occ});
  endfunction

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    n_tot++;
    if (a !== e) $display("FAIL %s: got %h expected %h", n, a, e);
    else n_pass++;
  endtask

  task automatic idle();
    flush = 0; den = 0; ack = 0; cv = '0; ct = '0; cr = '0;
    d_r1v = 0; d_r2v = 0; d_r1t = '0; d_r2t = '0; d_r1d = '0; d_r2d = '0; d_rd = '0; d_pl = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [TW-1:0] rd, input logic av, input logic [TW-1:0] at, input logic [DW-1:0] ad,
                      input logic bv, input logic [TW-1:0] bt, input logic [DW-1:0] bd);
    den = 1; d_rd = rd; d_pl = PW'(rd);
    d_r1v = av; d_r1t = at; d_r1d = ad; d_r2v = bv; d_r2t = bt; d_r2d = bd;
  endtask

  function automatic ment_t mwake(input ment_t e);
    ment_t r = e;
    for (int c = 0; c < NC; c++)
      if (cv[c]) begin
        if (!e.a_v && e.a_t == ct[c*TW +: TW]) begin r.a_v = 1; r.a_d = cr[c*DW +: DW]; end
        if (!e.b_v && e.b_t == ct[c*TW +: TW]) begin r.b_v = 1; r.b_d = cr[c*DW +: DW]; end
      end
    return r;
  endfunction

  function automatic int msel();
    foreach (mq[i]) if (mq[i].a_v && mq[i].b_v) return i;
    return -1;
  endfunction

  function automatic logic [127:0] mexp();
    int s = msel();
    logic f = mq.size() == DEPTH;
    logic e = mq.size() == 0;
    logic [2:0] o = 3'(mq.size());
    if (s < 0) return expv(f, e, 0, '0, '0, '0, '0, o);
    return expv(f, e, 1, mq[s].rd, mq[s].a_d, mq[s].b_d, mq[s].pl, o);
  endfunction

  task automatic mstep();
    int s;
    bit iss, dacc;
    ment_t e;
    if (rst || flush) begin
      mq.delete();
      return;
    end
    s = msel();
    iss = ack && s >= 0;
    dacc = den && mq.size() < DEPTH;
    foreach (mq[i]) mq[i] = mwake(mq[i]);
    if (iss) mq.delete(s);
    if (dacc) begin
      e = '{d_r1v, d_r1t, d_r1d, d_r2v, d_r2t, d_r2d, d_rd, d_pl};
`ifdef CDB_DISPATCH_BYPASS_EN
      e = mwake(e);
`endif
      mq.push_back(e);
    end
  endtask

  initial begin
    logic [DW-1:0] er1, er2;
    int t0;
    idle();
    tick();
    tick();
    rst = 0;
    chk("reset", obs(), expv(0, 1, 0, '0, '0, '0, '0, 0));

    tbl.push_back(mkv(0, 1, 1, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mkv(0, 1, 2, 0, 0, 0, 1, 1, 2));
    tbl.push_back(mkv(0, 1, 3, 0, 0, 0, 1, 1, 3));
    tbl.push_back(mkv(0, 1, 4, 0, 1, 0, 1, 1, 4));
    tbl.push_back(mkv(0, 1, 5, 0, 1, 0, 1, 1, 4));
    tbl.push_back(mkv(0, 1, 5, 1, 0, 0, 1, 2, 3));
    tbl.push_back(mkv(0, 1, 6, 1, 0, 0, 1, 3, 3));
    tbl.push_back(mkv(0, 0, 0, 1, 0, 0, 1, 4, 2));
    tbl.push_back(mkv(0, 0, 0, 1, 0, 0, 1, 6, 1));
    tbl.push_back(mkv(0, 1, 7, 0, 0, 0, 1, 6, 2));
    tbl.push_back(mkv(0, 1, 8, 0, 0, 0, 1, 6, 3));
    tbl.push_back(mkv(1, 1, 9, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mkv(0, 0, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mkv(0, 1, 10, 0, 0, 0, 1, 10, 1));
    tbl.push_back(mkv(0, 0, 0, 1, 0, 1, 0, 0, 0));
    foreach (tbl[i]) begin
      idle();
      flush = tbl[i].flush;
      ack = tbl[i].ack;
      if (tbl[i].den) disp(tbl[i].rd, 1, '0, 32'(tbl[i].rd) * 16 + 1, 1, '0, 32'(tbl[i].rd) * 16 + 2);
      tick();
      er1 = tbl[i].e_iv ? 32'(tbl[i].e_rd) * 16 + 1 : '0;
      er2 = tbl[i].e_iv ? 32'(tbl[i].e_rd) * 16 + 2 : '0;
      chk($sformatf("vec%0d", i), obs(),
          expv(tbl[i].e_full, tbl[i].e_empty, tbl[i].e_iv, tbl[i].e_rd, er1, er2,
               tbl[i].e_iv ? PW'(tbl[i].e_rd) : '0, tbl[i].e_occ));
    end

    idle(); disp(7, 0, 5, '0, 1, '0, 32'h70); tick();
    chk("wait_not_ready", obs(), expv(0, 0, 0, '0, '0, '0, '0, 1));
    idle(); disp(8, 1, '0, 32'h81, 1, '0, 32'h82); tick();
    chk("younger_first", obs(), expv(0, 0, 1, 8, 32'h81, 32'h82, 17'd8, 2));
    idle(); ack = 1; tick();
    chk("after_issue8", obs(), expv(0, 0, 0, '0, '0, '0, '0, 1));
    idle(); cv = 2'b01; ct[0 +: TW] = 5; cr[0 +: DW] = 32'hDEAD; #1;
    chk("wake_same_cycle", obs(), expv(0, 0, 0, '0, '0, '0, '0, 1));
    tick();
    chk("wake_next_cycle", obs(), expv(0, 0, 1, 7, 32'hDEAD, 32'h70, 17'd7, 1));
    idle(); ack = 1; tick();
    chk("drain7", obs(), expv(0, 1, 0, '0, '0, '0, '0, 0));

    idle(); disp(10, 0, 3, '0, 0, 9, '0); tick();
    idle(); cv = 2'b11; ct = {6'd9, 6'd3}; cr = {32'h22, 32'h11}; tick();
    chk("dual_cdb", obs(), expv(0, 0, 1, 10, 32'h11, 32'h22, 17'd10, 1));
    idle(); ack = 1; tick();

    idle(); disp(11, 1, '0, 32'h33, 0, 12, '0); cv = 2'b01; ct[0 +: TW] = 12; cr[0 +: DW] = 32'h55; tick();
`ifdef CDB_DISPATCH_BYPASS_EN
    chk("bypass", obs(), expv(0, 0, 1, 11, 32'h33, 32'h55, 17'd11, 1));
`else
    chk("no_bypass", obs(), expv(0, 0, 0, '0, '0, '0, '0, 1));
`endif
    idle(); tick(); tick(); tick();
`ifdef CDB_DISPATCH_BYPASS_EN
    chk("bypass_hold", obs(), expv(0, 0, 1, 11, 32'h33, 32'h55, 17'd11, 1));
`else
    chk("no_bypass_stuck", obs(), expv(0, 0, 0, '0, '0, '0, '0, 1));
`endif
    idle(); flush = 1; tick();
    chk("flush_clear", obs(), expv(0, 1, 0, '0, '0, '0, '0, 0));

    idle(); disp(12, 1, '0, 32'h1, 1, '0, 32'h2); tick();
    idle(); disp(13, 1, '0, 32'h3, 1, '0, 32'h4); rst = 1; tick();
    rst = 0;
    chk("mid_reset", obs(), expv(0, 1, 0, '0, '0, '0, '0, 0));

    idle(); rst = 1; tick(); rst = 0;
    mq.delete();
    chk("rand_reset", obs(), mexp());
    for (int k = 0; k < 400; k++) begin
      idle();
      flush = ($urandom % 40) == 0;
      ack = $urandom % 2;
      if ($urandom % 4 != 0)
        disp(TW'($urandom), $urandom % 2, TW'($urandom_range(0, 15)), $urandom,
             $urandom % 2, TW'($urandom_range(0, 15)), $urandom);
      d_pl = PW'($urandom);
      cv = NC'($urandom);
      t0 = $urandom_range(0, 15);
      ct = {TW'((t0 + $urandom_range(1, 15)) % 16), TW'(t0)};
      cr = {$urandom, $urandom};
      mstep();
      tick();
      chk($sformatf("rand%0d", k), obs(), mexp());
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/cdb_issue_queue.md
Name: cdb_issue_queue

Overview:
- Parametrised reservation-station queue for one execution unit of the out-of-order core.
- Generalises the single-CDB int/ld-st/mult/div FIFOs to configurable depth, payload width and CDB channel count, with age-ordered out-of-order issue.
- Sits between the dispatcher and one functional unit.
- Snoops all CDB channels to wake operands; issues the oldest entry whose operands are both ready.

Parameters:
DEPTH, 4, number of entries (>=2)
TAG_W, 6, ROB/rename tag width
DATA_W, 32, operand data width
PAYLOAD_W, 17, opaque per-instruction payload (opcode+func3+func7 for INT)
N_CDB, 1, number of CDB broadcast channels (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  mispredict flush; empties queue
dispatch_en  in  1  write new entry
dispatch_rs1_data / dispatch_rs2_data  in  DATA_W  operand value
dispatch_rs1_valid / dispatch_rs2_valid  in  1  operand value present
dispatch_rs1_tag / dispatch_rs2_tag  in  TAG_W  producer tag if not valid
dispatch_rd_tag  in  TAG_W  destination tag
dispatch_payload  in  PAYLOAD_W  opaque payload
queue_full  out  1  count==DEPTH
queue_empty  out  1  count==0
cdb_valid  in  N_CDB  per-channel broadcast valid
cdb_tag  in  N_CDB*TAG_W  flat, channel i at [i*TAG_W +: TAG_W]
cdb_result  in  N_CDB*DATA_W  flat, same packing
issue_valid  out  1  a ready entry is presented
issue_ack  in  1  unit accepts presented entry
issue_rs1_data / issue_rs2_data  out  DATA_W  operands of selected entry
issue_rd_tag  out  TAG_W  destination tag
issue_payload  out  PAYLOAD_W  payload
occupancy  out  $clog2(DEPTH+1)  valid-entry count

Behaviour:
- One clock (clk); reset synchronous, active-high (rst).
- Reset: all entry valid bits 0, count 0. queue_empty=1; queue_full=0; issue_valid=0; occupancy=0; issue data outputs 0.
- Storage: compacting array, index 0 = oldest.
- Select: issue_valid = OR over entries of (valid & rs1_valid & rs2_valid). Selected entry = lowest ready index. Issue outputs are combinational from registered state (zero-latency present).
- Handshake: entry removed at the clock edge where issue_valid & issue_ack. Entries above it shift down one. issue_ack while issue_valid=0 is ignored. Outputs hold while valid & !ack.
- Wakeup: each stored operand with valid=0 compares its tag to every channel with cdb_valid=1. On match, the operand captures cdb_result and sets valid at the edge. Wakeup also applies to entries being shifted that cycle. Tags are unique in flight; multiple simultaneous matches are illegal (assertion). A woken entry is issue-eligible the next cycle, never the same cycle.
- Dispatch: when dispatch_en & !queue_full, the entry is written at index count, or count-1 if an issue is accepted the same edge.
  - dispatch_en while queue_full: entry dropped, even if an issue frees a slot that edge; the dispatcher must stall on queue_full.
- Occupancy next = count + dispatch_accepted - issue_accepted. Dispatch and issue in the same cycle leave count unchanged.
- Flush: highest priority. Next state is empty regardless of dispatch/issue/CDB that cycle; an issue_ack in that cycle is still a legal handshake for the unit.
- rst mid-operation: same effect as flush, plus outputs return to their reset values.
- Full/empty: queue_full and queue_empty are decoded from registered count only.

Optional Feature:
CDB_DISPATCH_BYPASS_EN
- Defined: a dispatched operand with valid=0 whose tag matches a valid CDB channel in the dispatch cycle is written as valid with that cdb_result.
- Undefined: dispatched operands are stored exactly as presented. The dispatcher must resolve same-cycle broadcasts itself; otherwise the operand is never woken.

Decomposition:
- Shared package: iq_entry_t struct {valid, rs1/rs2 data, valid, tag, rd_tag, payload}, parameterised via typedef in the module. Add constant CDB_CH_DEFAULT=1 alongside cdb_bfm.
- One natural sub-module: iq_oldest_ready_sel, a DEPTH-wide priority encoder returning one-hot and index of the lowest ready entry.

Test Plan:
- Reset then dispatch 4 ready entries (rd_tag 1..4), DEPTH=4 → queue_full=1, occupancy=4. 5th dispatch dropped. Acks issue tags 1,2,3,4 in order.
- Dispatch rd_tag 7 with rs1 tag 5 not valid, then rd_tag 8 ready → tag 8 issues first. CDB tag 5 result 0xDEAD → next cycle tag 7 issues with rs1=0xDEAD.
- N_CDB=2: entry waiting on tags 3 and 9; ch0 tag 3 = 0x11 and ch1 tag 9 = 0x22 same cycle → issues next cycle with 0x11/0x22.
- Full queue, dispatch_en and issue_ack same cycle → dispatch dropped, occupancy 3. Half-full simultaneous dispatch + issue → occupancy unchanged, new entry at tail.
- flush asserted with 3 entries plus a concurrent dispatch → next cycle queue_empty=1, occupancy=0, issue_valid=0.
- With CDB_DISPATCH_BYPASS_EN: dispatch rs2 tag 12 not valid while CDB broadcasts tag 12 = 0x55 → entry issues next cycle with rs2=0x55. Without the macro → entry never issues.
